ring_step_monitor: RTL

Downstream monitor for the four-stage D flip-flop ring: samples the ring outputs each time the ring advances and checks that the circulating token moves one stage per step. It locks onto the pattern, reports token position and completed rotations, and counts sequence errors, escalating to a sticky fault. It sits directly after the ring and is the only consumer of its Q outputs.

---
 rtl/ring_mon_pkg.sv | 44 ++++
 rtl/ring_code_decode.sv | 50 +++++
 rtl/ring_step_monitor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ring_mon_pkg.sv
// rtl/ring_mon_pkg.sv - shared types, defaults and next-code helper for ring_step_monitor
// Purpose: FSM state encoding, default parameter values and the expected-next-code
//          function used by the monitor.
// Macro:   RING_MON_JOHNSON_EN selects Johnson ring codes instead of one-hot.
// Ports:   none (package)
package ring_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_LOCK  = 2'd2,
    ST_FAULT = 2'd3
  } mon_state_t;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_SYNC_STEPS = 2;
  localparam int DEF_ERR_LIMIT  = 3;
  localparam int DEF_ROT_W      = 8;

  // Widest ring the helper below can handle; callers zero-extend into it.
  localparam int CODE_MAX_W     = 32;

`ifdef RING_MON_JOHNSON_EN
  localparam bit JOHNSON_MODE = 1'b1;
`else
  localparam bit JOHNSON_MODE = 1'b0;
`endif

  // Shift the code one stage toward the MSB; the top stage wraps into bit 0,
  // inverted for a Johnson ring. Shifts avoid variable bit-selects.
  function automatic logic [CODE_MAX_W-1:0] next_code(
    input logic [CODE_MAX_W-1:0] code,
    input int                    width,
    input bit                    johnson
  );
    logic [CODE_MAX_W-1:0] r;
    logic [CODE_MAX_W-1:0] top;
    r    = (code << 1) & ~({CODE_MAX_W{1'b1}} << width);
    top  = code >> (width - 1);
    r[0] = top[0] ^ johnson;
    return r;
  endfunction

endpackage

// File: rtl/ring_code_decode.sv
// rtl/ring_code_decode.sv - combinational ring code legality check and position decode
// Purpose: classifies a ring sample as a legal ring code and returns its position
//          in the circulation sequence.
// Macro:   RING_MON_JOHNSON_EN -> 2*WIDTH Johnson codes (pos 0 = all zeros);
//          undefined -> WIDTH one-hot codes (pos = index of the set bit).
// Ports:   ring_q (in, WIDTH)  sampled ring outputs
//          legal  (out, 1)     sample is a valid ring code
//          pos    (out, POS_W) position of the code; 0 when not legal
module ring_code_decode
  import ring_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int POS_W = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] ring_q,
  output logic             legal,
  output logic [POS_W-1:0] pos
);

`ifdef RING_MON_JOHNSON_EN
  localparam int NCODES = 2*WIDTH;
`else
  localparam int NCODES = WIDTH;
`endif

  // Code occupying position k of the sequence.
  function automatic logic [WIDTH-1:0] code_of(input int k);
    logic [WIDTH-1:0] ones;
    ones = '1;
`ifdef RING_MON_JOHNSON_EN
    // First half fills with ones from bit 0, second half drains them from bit 0.
    if (k <= WIDTH) return ~(ones << k);
    else            return ones << (k - WIDTH);
`else
    return WIDTH'(1) << k;
`endif
  endfunction

  always_comb begin
    legal = 1'b0;
    pos   = '0;
    for (int k = 0; k < NCODES; k++) begin
      if (ring_q == code_of(k)) begin
        legal = 1'b1;
        pos   = POS_W'(k);
      end
    end
  end

endmodule

// File: rtl/ring_step_monitor.sv
// rtl/ring_step_monitor.sv - token-step checker for a D flip-flop ring
// Purpose: samples the ring on each ring_step, locks onto the circulating token,
//          reports position and completed rotations, counts sequence errors and
//          escalates to a sticky fault.
// Macro:   RING_MON_JOHNSON_EN selects Johnson ring codes (default one-hot).
// Ports:   clk        (in)         rising-edge clock
//          rst_n      (in)         asynchronous active-low reset
//          ring_q     (in, WIDTH)  ring stage outputs, bit 0 = first stage
//          ring_step  (in)         ring advanced; ring_q sampled this edge
//          clear      (in)         synchronous clear to IDLE, wins over ring_step
//          pos        (out, POS_W) position of last accepted sample
//          locked     (out)        high in LOCK
//          fault      (out)        high in FAULT (sticky until clear/reset)
//          rot_cnt    (out, ROT_W) rotations completed since lock, saturating
//          err_pulse  (out)        one-cycle pulse per mismatching step in LOCK
//          err_cnt    (out, 8)     total mismatches, saturating at 255
module ring_step_monitor
  import ring_mon_pkg::*;
#(
  parameter  int WIDTH      = DEF_WIDTH,
  parameter  int SYNC_STEPS = DEF_SYNC_STEPS,
  parameter  int ERR_LIMIT  = DEF_ERR_LIMIT,
  parameter  int ROT_W      = DEF_ROT_W,
  localparam int POS_W      = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ring_q,
  input  logic             ring_step,
  input  logic             clear,
  output logic [POS_W-1:0] pos,
  output logic             locked,
  output logic             fault,
  output logic [ROT_W-1:0] rot_cnt,
  output logic             err_pulse,
  output logic [7:0]       err_cnt
);

  localparam int SC_W = $clog2(SYNC_STEPS + 1);
  localparam int CE_W = $clog2(ERR_LIMIT + 1);

  mon_state_t       state, state_d;
  logic [WIDTH-1:0] prev, prev_d;
  logic [SC_W-1:0]  sync_cnt, sync_d;
  logic [CE_W-1:0]  consec_err, consec_d;
  logic [POS_W-1:0] pos_d;
  logic [ROT_W-1:0] rot_d;
  logic [7:0]       errc_d;
  logic             pulse_d;

  logic             legal;
  logic [POS_W-1:0] dec_pos;
  logic [WIDTH-1:0] exp_code;
  logic             match;

  ring_code_decode #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_decode (
    .ring_q (ring_q),
    .legal  (legal),
    .pos    (dec_pos)
  );

  assign exp_code = WIDTH'(next_code(CODE_MAX_W'(prev), WIDTH, JOHNSON_MODE));
  assign match    = legal && (ring_q == exp_code);

  always_comb begin
    state_d  = state;
    prev_d   = prev;
    sync_d   = sync_cnt;
    consec_d = consec_err;
    pos_d    = pos;
    rot_d    = rot_cnt;
    errc_d   = err_cnt;
    pulse_d  = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      prev_d   = '0;
      sync_d   = '0;
      consec_d = '0;
      pos_d    = '0;
      rot_d    = '0;
      errc_d   = '0;
    end else if (ring_step) begin
      unique case (state)
        ST_IDLE: begin
          if (legal) begin
            state_d = ST_SYNC;
            prev_d  = ring_q;
            sync_d  = '0;
            pos_d   = dec_pos;
          end
        end
        ST_SYNC: begin
          if (match) begin
            prev_d = ring_q;
            pos_d  = dec_pos;
            sync_d = sync_cnt + SC_W'(1);
            if (sync_cnt + SC_W'(1) == SC_W'(SYNC_STEPS)) begin
              state_d = ST_LOCK;
              rot_d   = '0;
            end
          end else if (legal) begin
            // Restart the run of correct steps from this sample.
            prev_d = ring_q;
            pos_d  = dec_pos;
            sync_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (match) begin
            prev_d   = ring_q;
            pos_d    = dec_pos;
            consec_d = '0;
            if (dec_pos == '0 && rot_cnt != '1) rot_d = rot_cnt + ROT_W'(1);
          end else begin
            // Expectation keeps free-running so a single glitch does not
            // desynchronise the following good steps.
            pulse_d  = 1'b1;
            prev_d   = exp_code;
            consec_d = consec_err + CE_W'(1);
            if (err_cnt != 8'hff) errc_d = err_cnt + 8'd1;
            if (consec_err + CE_W'(1) == CE_W'(ERR_LIMIT)) state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prev       <= '0;
      sync_cnt   <= '0;
      consec_err <= '0;
      pos        <= '0;
      rot_cnt    <= '0;
      err_cnt    <= '0;
      err_pulse  <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      prev       <= prev_d;
      sync_cnt   <= sync_d;
      consec_err <= consec_d;
      pos        <= pos_d;
      rot_cnt    <= rot_d;
      err_cnt    <= errc_d;
      err_pulse  <= pulse_d;
      locked     <= (state_d == ST_LOCK);
      fault      <= (state_d == ST_FAULT);
    end
  end

endmodule
